// File: rtl/traffic_light_controller_adaptive.sv
// Four-way adaptive traffic light controller: round-robin green/yellow phases whose green
// length follows per-approach density, with ambulance pre-emption through an all-red clearance.
module traffic_light_controller_adaptive #(
  parameter int MIN_GREEN       = 2,
  parameter int MAX_GREEN       = 15,
  parameter int YELLOW_TIME     = 2,
  parameter int EMERG_WAIT_TIME = 2
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       amb_n,
  input  logic       amb_s,
  input  logic       amb_e,
  input  logic       amb_w,
  input  logic [3:0] density_n,
  input  logic [3:0] density_s,
  input  logic [3:0] density_e,
  input  logic [3:0] density_w,
  output logic [2:0] n_lights,
  output logic [2:0] s_lights,
  output logic [2:0] e_lights,
  output logic [2:0] w_lights,
  output logic       emergency_mode
);

  typedef enum logic [3:0] {
    N_GREEN    = 4'd0,
    N_YELLOW   = 4'd1,
    S_GREEN    = 4'd2,
    S_YELLOW   = 4'd3,
    E_GREEN    = 4'd4,
    E_YELLOW   = 4'd5,
    W_GREEN    = 4'd6,
    W_YELLOW   = 4'd7,
    EMERG_WAIT = 4'd8,
    EMERG_N    = 4'd9,
    EMERG_S    = 4'd10,
    EMERG_E    = 4'd11,
    EMERG_W    = 4'd12
  } state_t;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(EMERG_WAIT_TIME - 1);

  // Handshake-free block: amb_* are level requests sampled every rising edge, no ack.

  state_t     state;
  state_t     w_next_state;
  logic [7:0] r_timer;
  logic [3:0] r_green_len;
  logic [1:0] r_resume;

  logic [3:0] w_amb;
  logic       w_req;
  logic [1:0] w_target;
  logic [1:0] w_idx;
  logic [1:0] w_idx_next;
  logic       w_green_last;
  logic       w_yellow_last;
  logic       w_wait_last;
  logic       w_resume_set;
  logic [1:0] w_resume_val;
  logic       w_enter_green;
  logic [3:0] w_entry_density;
  logic [2:0] w_lamp [4];

  function automatic logic [3:0] clamp_density(input logic [3:0] d);
    if (int'(d) < MIN_GREEN) return 4'(MIN_GREEN);
    if (int'(d) > MAX_GREEN) return 4'(MAX_GREEN);
    return d;
  endfunction

  function automatic state_t green_of(input logic [1:0] idx);
    return state_t'({1'b0, idx, 1'b0});
  endfunction

  function automatic state_t yellow_of(input logic [1:0] idx);
    return state_t'({1'b0, idx, 1'b1});
  endfunction

  function automatic state_t emerg_of(input logic [1:0] idx);
    return state_t'(4'd9 + {2'b00, idx});
  endfunction

  assign w_amb = {amb_w, amb_e, amb_s, amb_n};
  assign w_req = |w_amb;

  // Fixed priority N > S > E > W when several ambulances are present.
  always_comb begin
    w_target = 2'd3;
    if (w_amb[0])      w_target = 2'd0;
    else if (w_amb[1]) w_target = 2'd1;
    else if (w_amb[2]) w_target = 2'd2;
  end

  assign w_green_last  = (r_timer >= ({4'd0, r_green_len} - 8'd1));
  assign w_yellow_last = (r_timer >= YELLOW_LAST);
  assign w_wait_last   = (r_timer >= WAIT_LAST);
  assign w_idx_next    = w_idx + 2'd1;

  always_comb begin
    w_next_state = state;
    w_resume_set = 1'b0;
    w_resume_val = w_idx_next;
    w_idx        = state[2:1];
    case (state)
      N_GREEN, S_GREEN, E_GREEN, W_GREEN: begin
        if (w_req) begin
          if (w_amb[w_idx]) w_next_state = emerg_of(w_idx);
          else              w_next_state = yellow_of(w_idx);
        end else if (w_green_last) begin
          w_next_state = yellow_of(w_idx);
        end
      end
      N_YELLOW, S_YELLOW, E_YELLOW, W_YELLOW: begin
        if (w_yellow_last) begin
          if (w_req) begin
            w_next_state = EMERG_WAIT;
            w_resume_set = 1'b1;
          end else begin
            w_next_state = green_of(w_idx_next);
          end
        end
      end
      EMERG_WAIT: begin
        if (w_wait_last) begin
          if (w_req) w_next_state = emerg_of(w_target);
          else       w_next_state = green_of(r_resume);
        end
      end
      EMERG_N, EMERG_S, EMERG_E, EMERG_W: begin
        w_idx = 2'(state - EMERG_N);
        // Served ambulance keeps the junction until it leaves; others queue behind it.
        if (!w_amb[w_idx]) begin
          if (w_req) begin
            w_next_state = EMERG_WAIT;
            w_resume_set = 1'b1;
          end else begin
            w_next_state = yellow_of(w_idx);
          end
        end
      end
      default: w_next_state = N_GREEN;
    endcase
  end

  assign w_enter_green = (w_next_state != state) && (w_next_state[3] == 1'b0) &&
                         (w_next_state[0] == 1'b0);

  always_comb begin
    w_entry_density = density_n;
    case (w_next_state[2:1])
      2'd1:    w_entry_density = density_s;
      2'd2:    w_entry_density = density_e;
      2'd3:    w_entry_density = density_w;
      default: w_entry_density = density_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state       <= N_GREEN;
      r_timer     <= '0;
      r_green_len <= clamp_density(density_n);
      r_resume    <= 2'd1;
    end else begin
      state <= w_next_state;
      if (w_next_state != state)  r_timer <= '0;
      else if (r_timer != 8'hFF)  r_timer <= r_timer + 8'd1;
      if (w_enter_green)          r_green_len <= clamp_density(w_entry_density);
      if (w_resume_set)           r_resume <= w_resume_val;
    end
  end

  // Lamp decode: at most one approach is ever non-red; EMERG_WAIT is all red.
  always_comb begin
    for (int i = 0; i < 4; i++) w_lamp[i] = LAMP_RED;
    emergency_mode = 1'b0;
    case (state)
      N_GREEN:    w_lamp[0] = LAMP_GREEN;
      N_YELLOW:   w_lamp[0] = LAMP_YELLOW;
      S_GREEN:    w_lamp[1] = LAMP_GREEN;
      S_YELLOW:   w_lamp[1] = LAMP_YELLOW;
      E_GREEN:    w_lamp[2] = LAMP_GREEN;
      E_YELLOW:   w_lamp[2] = LAMP_YELLOW;
      W_GREEN:    w_lamp[3] = LAMP_GREEN;
      W_YELLOW:   w_lamp[3] = LAMP_YELLOW;
      EMERG_WAIT: emergency_mode = 1'b1;
      EMERG_N: begin w_lamp[0] = LAMP_GREEN; emergency_mode = 1'b1; end
      EMERG_S: begin w_lamp[1] = LAMP_GREEN; emergency_mode = 1'b1; end
      EMERG_E: begin w_lamp[2] = LAMP_GREEN; emergency_mode = 1'b1; end
      EMERG_W: begin w_lamp[3] = LAMP_GREEN; emergency_mode = 1'b1; end
      default: emergency_mode = 1'b0;
    endcase
  end

  assign n_lights = w_lamp[0];
  assign s_lights = w_lamp[1];
  assign e_lights = w_lamp[2];
  assign w_lights = w_lamp[3];

endmodule

// File: tb/tb_traffic_light_controller_adaptive.sv
// Bench for the adaptive traffic light controller: directed scenarios plus random ambulance
// and density traffic, checked every cycle against a phase-level reference model.
module tb_traffic_light_controller_adaptive;

  localparam int YEL  = 2;
  localparam int WAIT = 2;
  localparam int K_GREEN  = 0;
  localparam int K_YELLOW = 1;
  localparam int K_WAIT   = 2;
  localparam int K_EMERG  = 3;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YLW = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  logic       clk;
  logic       rst_a;
  logic [3:0] amb;
  logic [3:0] dens [4];
  logic [2:0] n_lights, s_lights, e_lights, w_lights;
  logic       emergency_mode;

  int n_total;
  int n_bad;

  // reference model: current phase kind, approach, cycles left, approach to resume at
  int m_kind;
  int m_dir;
  int m_left;
  int m_resume;

  traffic_light_controller_adaptive dut (
    .clk            (clk),
    .rst_a          (rst_a),
    .amb_n          (amb[0]),
    .amb_s          (amb[1]),
    .amb_e          (amb[2]),
    .amb_w          (amb[3]),
    .density_n      (dens[0]),
    .density_s      (dens[1]),
    .density_e      (dens[2]),
    .density_w      (dens[3]),
    .n_lights       (n_lights),
    .s_lights       (s_lights),
    .e_lights       (e_lights),
    .w_lights       (w_lights),
    .emergency_mode (emergency_mode)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int green_len(input int d);
    if (d < 2)  return 2;
    if (d > 15) return 15;
    return d;
  endfunction

  task automatic enter(input int kind, input int dir);
    m_kind = kind;
    m_dir  = dir;
    if (kind == K_GREEN)       m_left = green_len(int'(dens[dir]));
    else if (kind == K_YELLOW) m_left = YEL;
    else if (kind == K_WAIT)   m_left = WAIT;
    else                       m_left = 0;
  endtask

  task automatic model_step();
    int tgt;
    tgt = 3;
    for (int i = 3; i >= 0; i--) if (amb[i]) tgt = i;
    if (rst_a) begin
      enter(K_GREEN, 0);
      return;
    end
    case (m_kind)
      K_GREEN: begin
        if (amb != 0)       enter(amb[m_dir] ? K_EMERG : K_YELLOW, m_dir);
        else if (m_left == 1) enter(K_YELLOW, m_dir);
        else                m_left--;
      end
      K_YELLOW: begin
        if (m_left == 1) begin
          if (amb != 0) begin
            m_resume = (m_dir + 1) % 4;
            enter(K_WAIT, m_dir);
          end else begin
            enter(K_GREEN, (m_dir + 1) % 4);
          end
        end else m_left--;
      end
      K_WAIT: begin
        if (m_left == 1) begin
          if (amb != 0) enter(K_EMERG, tgt);
          else          enter(K_GREEN, m_resume);
        end else m_left--;
      end
      default: begin
        if (!amb[m_dir]) begin
          if (amb != 0) begin
            m_resume = (m_dir + 1) % 4;
            enter(K_WAIT, m_dir);
          end else begin
            enter(K_YELLOW, m_dir);
          end
        end
      end
    endcase
  endtask

  function automatic logic [2:0] exp_lamp(input int dir);
    if (m_kind == K_WAIT || dir != m_dir) return RED;
    if (m_kind == K_YELLOW) return YLW;
    return GRN;
  endfunction

  function automatic int exp_code();
    if (m_kind == K_GREEN)  return 2 * m_dir;
    if (m_kind == K_YELLOW) return 2 * m_dir + 1;
    if (m_kind == K_WAIT)   return 8;
    return 9 + m_dir;
  endfunction

  task automatic check_all();
    int non_red;
    non_red = int'(n_lights != RED) + int'(s_lights != RED) +
              int'(e_lights != RED) + int'(w_lights != RED);
    check("n_lights", 32'(n_lights), 32'(exp_lamp(0)));
    check("s_lights", 32'(s_lights), 32'(exp_lamp(1)));
    check("e_lights", 32'(e_lights), 32'(exp_lamp(2)));
    check("w_lights", 32'(w_lights), 32'(exp_lamp(3)));
    check("emergency_mode", 32'(emergency_mode), 32'(m_kind == K_WAIT || m_kind == K_EMERG));
    check("state", 32'(dut.state), 32'(exp_code()));
    check("onehot_lamps", 32'($onehot(n_lights) && $onehot(s_lights) &&
                               $onehot(e_lights) && $onehot(w_lights)), 32'd1);
    check("non_red_count", 32'(non_red <= 1), 32'd1);
  endtask

  // driver: inputs change at negedge; model and DUT both consume them at the next posedge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic set_dens(input int dn, input int ds, input int de, input int dw);
    dens[0] = 4'(dn);
    dens[1] = 4'(ds);
    dens[2] = 4'(de);
    dens[3] = 4'(dw);
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    run(2);
    rst_a = 1'b0;
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    m_kind   = K_GREEN;
    m_dir    = 0;
    m_left   = 2;
    m_resume = 1;
    amb      = 4'b0000;
    rst_a    = 1'b1;
    set_dens(8, 8, 8, 8);

    // uniform density: 40-cycle rotation
    do_reset();
    check("reset_mode", 32'(emergency_mode), 32'd0);
    check("reset_n_green", 32'(n_lights), 32'(GRN));
    run(85);

    // skewed densities, then saturated-low densities
    set_dens(15, 3, 10, 5);
    do_reset();
    run(80);
    set_dens(0, 1, 2, 0);
    do_reset();
    run(40);

    // amb_s arrives during N_GREEN
    set_dens(8, 8, 8, 8);
    do_reset();
    run(2);
    amb[1] = 1'b1;
    run(12);
    amb[1] = 1'b0;
    run(20);

    // amb_n and amb_w together during N_GREEN, then dropping together
    do_reset();
    run(1);
    amb = 4'b1001;
    run(8);
    amb = 4'b0000;
    run(20);

    // amb_w still held when amb_n clears
    do_reset();
    run(1);
    amb = 4'b1001;
    run(6);
    amb = 4'b1000;
    run(10);
    amb = 4'b0000;
    run(15);

    // reset while serving an east ambulance
    amb = 4'b0100;
    begin
      int waited;
      waited = 0;
      while (!(m_kind == K_EMERG && m_dir == 2) && waited < 100) begin
        run(1);
        waited++;
      end
      check("reach_emerg_e", 32'(m_kind == K_EMERG && m_dir == 2), 32'd1);
    end
    run(3);
    rst_a = 1'b1;
    amb   = 4'b0000;
    run(1);
    rst_a = 1'b0;
    check("rst_emerg_mode", 32'(emergency_mode), 32'd0);
    check("rst_emerg_n", 32'(n_lights), 32'(GRN));
    run(10);

    // random traffic and ambulances
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) dens[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) begin
        if (amb[b]) begin
          if ($urandom_range(0, 14) == 0) amb[b] = 1'b0;
        end else if ($urandom_range(0, 79) == 0) begin
          amb[b] = 1'b1;
        end
      end
      rst_a = ($urandom_range(0, 599) == 0);
      run(1);
    end
    rst_a = 1'b0;
    amb   = 4'b0000;
    run(60);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
